// File: rtl/vend_ctrl.sv
// Vending transaction sequencer: accumulates coin credit, chooses vend or refund,
// times the dispense gate and pays change out one 5-unit coin per req/ack handshake.
module vend_ctrl #(
    parameter int PRICE_A    = 15,
    parameter int PRICE_B    = 25,
    parameter int MAX_CREDIT = 50,
    parameter int OPEN_MS    = 2000,
    parameter int TIMEOUT_MS = 10000
) (
    input  logic       sys_clk,
    input  logic       sys_rst,
    input  logic       tick_1ms,
    input  logic       coin5,
    input  logic       coin10,
    input  logic       sel_a,
    input  logic       sel_b,
    input  logic       cancel,
    input  logic       ret_ack,
    output logic [7:0] credit,
    output logic [7:0] price,
    output logic [7:0] change,
    output logic       open,
    output logic       ret_req,
    output logic       coin_reject,
    output logic       busy
);

    localparam int TIMER_MAX = (OPEN_MS > TIMEOUT_MS) ? OPEN_MS : TIMEOUT_MS;
    localparam int TW        = $clog2(TIMER_MAX + 1);

    localparam logic [7:0]    PRICE_A8     = 8'(PRICE_A);
    localparam logic [7:0]    PRICE_B8     = 8'(PRICE_B);
    localparam logic [8:0]    MAX_CREDIT9  = 9'(MAX_CREDIT);
    localparam logic [TW-1:0] OPEN_LAST    = TW'(OPEN_MS - 1);
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_MS - 1);

    typedef enum logic [1:0] {
        IDLE,
        CREDIT,
        DISPENSE,
        PAYOUT
    } state_t;

    state_t        state, state_n;
    logic [TW-1:0] timer, timer_n;
    logic [7:0]    credit_n, price_n, change_n;
    logic          open_n, ret_req_n, coin_reject_n, busy_n;

    logic [7:0] coin_val;
    logic       coin_in;
    logic [8:0] credit_sum;
    logic       coin_fits;
    logic [7:0] sel_price;
    logic       timeout_hit;
    logic       open_done;

    assign coin_val    = (coin5 ? 8'd5 : 8'd0) + (coin10 ? 8'd10 : 8'd0);
    assign coin_in     = coin5 | coin10;
    assign credit_sum  = {1'b0, credit} + {1'b0, coin_val};
    assign coin_fits   = (credit_sum <= MAX_CREDIT9);
    assign sel_price   = sel_a ? PRICE_A8 : PRICE_B8;
    assign timeout_hit = tick_1ms && (timer == TIMEOUT_LAST);
    assign open_done   = tick_1ms && (timer == OPEN_LAST);

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state       <= IDLE;
            timer       <= '0;
            credit      <= 8'd0;
            price       <= 8'd0;
            change      <= 8'd0;
            open        <= 1'b0;
            ret_req     <= 1'b0;
            coin_reject <= 1'b0;
            busy        <= 1'b0;
        end else begin
            state       <= state_n;
            timer       <= timer_n;
            credit      <= credit_n;
            price       <= price_n;
            change      <= change_n;
            open        <= open_n;
            ret_req     <= ret_req_n;
            coin_reject <= coin_reject_n;
            busy        <= busy_n;
        end
    end

    always_comb begin
        state_n       = state;
        timer_n       = timer;
        credit_n      = credit;
        price_n       = price;
        change_n      = change;
        open_n        = open;
        ret_req_n     = ret_req;
        coin_reject_n = 1'b0;

        case (state)
            IDLE: begin
                if (coin_in) begin
                    if (coin_fits) begin
                        credit_n = credit_sum[7:0];
                        timer_n  = '0;
                        state_n  = CREDIT;
                    end else begin
                        coin_reject_n = 1'b1;
                    end
                end
            end

            CREDIT: begin
                timer_n = tick_1ms ? timer + 1'b1 : timer;
                // An idle timeout is handled exactly like a cancel.
                if (cancel || timeout_hit) begin
                    change_n      = credit;
                    credit_n      = 8'd0;
                    price_n       = 8'd0;
                    coin_reject_n = coin_in;
                    timer_n       = '0;
                    ret_req_n     = (credit != 8'd0);
                    state_n       = PAYOUT;
                end else if (coin_in) begin
                    if (coin_fits) begin
                        credit_n = credit_sum[7:0];
                        timer_n  = '0;
                    end else begin
                        coin_reject_n = 1'b1;
                    end
                end else if (sel_a || sel_b) begin
                    price_n = sel_price;
                    timer_n = '0;
                    if (credit >= sel_price) begin
                        change_n = credit - sel_price;
                        credit_n = 8'd0;
                        open_n   = 1'b1;
                        state_n  = DISPENSE;
                    end
                end
            end

            DISPENSE: begin
                coin_reject_n = coin_in;
                if (open_done) begin
                    open_n  = 1'b0;
                    price_n = 8'd0;
                    timer_n = '0;
                    if (change != 8'd0) begin
                        ret_req_n = 1'b1;
                        state_n   = PAYOUT;
                    end else begin
                        state_n = IDLE;
                    end
                end else if (tick_1ms) begin
                    timer_n = timer + 1'b1;
                end
            end

            PAYOUT: begin
                coin_reject_n = coin_in;
                // Drop the request for one cycle after every accepted coin.
                if (ret_req && ret_ack) begin
                    change_n  = change - 8'd5;
                    ret_req_n = 1'b0;
                    if (change == 8'd5) begin
                        state_n = IDLE;
                    end
                end else if (change == 8'd0) begin
                    ret_req_n = 1'b0;
                    state_n   = IDLE;
                end else begin
                    ret_req_n = 1'b1;
                end
            end

            default: begin
                state_n = IDLE;
            end
        endcase

        busy_n = (state_n == DISPENSE) || (state_n == PAYOUT);
    end

endmodule

// File: tb/tb_vend_ctrl.sv
// Self-checking bench for vend_ctrl: each stimulus cycle queues its expected
// outputs, which are popped and compared once the DUT has clocked that cycle.
module tb_vend_ctrl;

    // Stimulus bit masks: {sys_rst, coin5, coin10, sel_a, sel_b, cancel, ret_ack, tick_1ms}
    localparam logic [7:0] NONE = 8'h00;
    localparam logic [7:0] RST  = 8'h80;
    localparam logic [7:0] C5   = 8'h40;
    localparam logic [7:0] C10  = 8'h20;
    localparam logic [7:0] SA   = 8'h10;
    localparam logic [7:0] SB   = 8'h08;
    localparam logic [7:0] CN   = 8'h04;
    localparam logic [7:0] ACK  = 8'h02;
    localparam logic [7:0] TK   = 8'h01;

    logic       sys_clk = 1'b0;
    logic       sys_rst = 1'b0;
    logic       tick_1ms = 1'b0;
    logic       coin5 = 1'b0;
    logic       coin10 = 1'b0;
    logic       sel_a = 1'b0;
    logic       sel_b = 1'b0;
    logic       cancel = 1'b0;
    logic       ret_ack = 1'b0;
    logic [7:0] credit;
    logic [7:0] price;
    logic [7:0] change;
    logic       open;
    logic       ret_req;
    logic       coin_reject;
    logic       busy;

    typedef struct {
        string      tag;
        logic [7:0] credit;
        logic [7:0] price;
        logic [7:0] change;
        logic       open;
        logic       ret_req;
        logic       coin_reject;
        logic       busy;
    } exp_t;

    exp_t exp_q[$];
    int   check_count = 0;
    int   pass_count  = 0;
    int   req_cycles  = 0;
    int   req_base;

    vend_ctrl dut (
        .sys_clk    (sys_clk),
        .sys_rst    (sys_rst),
        .tick_1ms   (tick_1ms),
        .coin5      (coin5),
        .coin10     (coin10),
        .sel_a      (sel_a),
        .sel_b      (sel_b),
        .cancel     (cancel),
        .ret_ack    (ret_ack),
        .credit     (credit),
        .price      (price),
        .change     (change),
        .open       (open),
        .ret_req    (ret_req),
        .coin_reject(coin_reject),
        .busy       (busy)
    );

    // Free-running 10-time-unit system clock.
    always #5 sys_clk = ~sys_clk;

    // Count every clock edge at which the coin-return request is high, so a
    // phase can prove the actuator was never asked for a coin.
    always @(posedge sys_clk) begin
        if (ret_req === 1'b1) req_cycles <= req_cycles + 1;
    end

    // Stop a runaway simulation with a visible failure.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got no finish by time %0t, required finish earlier", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [7:0] got, input logic [7:0] want);
        check_count++;
        if (got === want) pass_count++;
        else $display("[TB] FAIL %s: got %0d, expected %0d", tag, got, want);
    endtask

    task automatic compareFront();
        exp_t e;
        if (exp_q.size() == 0) begin
            check_count++;
            $display("[TB] FAIL scoreboard: got empty queue, expected an entry");
            return;
        end
        e = exp_q.pop_front();
        checkOutput({e.tag, ".credit"}, credit, e.credit);
        checkOutput({e.tag, ".price"}, price, e.price);
        checkOutput({e.tag, ".change"}, change, e.change);
        checkOutput({e.tag, ".open"}, {7'd0, open}, {7'd0, e.open});
        checkOutput({e.tag, ".ret_req"}, {7'd0, ret_req}, {7'd0, e.ret_req});
        checkOutput({e.tag, ".coin_reject"}, {7'd0, coin_reject}, {7'd0, e.coin_reject});
        checkOutput({e.tag, ".busy"}, {7'd0, busy}, {7'd0, e.busy});
    endtask

    task automatic applyStimulus(input logic [7:0] stim, input string tag,
                                 input logic [7:0] e_credit, input logic [7:0] e_price,
                                 input logic [7:0] e_change, input logic e_open,
                                 input logic e_req, input logic e_rej, input logic e_busy);
        exp_t e;
        e.tag         = tag;
        e.credit      = e_credit;
        e.price       = e_price;
        e.change      = e_change;
        e.open        = e_open;
        e.ret_req     = e_req;
        e.coin_reject = e_rej;
        e.busy        = e_busy;
        @(negedge sys_clk);
        {sys_rst, coin5, coin10, sel_a, sel_b, cancel, ret_ack, tick_1ms} = stim;
        exp_q.push_back(e);
        @(posedge sys_clk);
        #1;
        {sys_rst, coin5, coin10, sel_a, sel_b, cancel, ret_ack, tick_1ms} = NONE;
        compareFront();
    endtask

    task automatic runTicks(input int n);
        repeat (n) begin
            @(negedge sys_clk);
            tick_1ms = 1'b1;
            @(posedge sys_clk);
            #1;
            tick_1ms = 1'b0;
        end
    endtask

    // Ack every request; the gap cycles also carry a stray ack that must be ignored.
    task automatic drainPayout(input int start);
        for (int c = start; c > 0; c -= 5) begin
            applyStimulus(ACK, "payout_ack", 8'd0, 8'd0, 8'(c - 5), 1'b0, 1'b0, 1'b0, (c - 5) != 0);
            if (c - 5 != 0)
                applyStimulus(ACK, "payout_gap", 8'd0, 8'd0, 8'(c - 5), 1'b0, 1'b1, 1'b0, 1'b1);
        end
    endtask

    // Main scripted sequence: each phase drives a transaction and states its outputs.
    initial begin
        applyStimulus(RST, "reset0", 8'd0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(RST, "reset1", 8'd0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0);

        $display("[TB] exact-price vend of product A");
        applyStimulus(C10, "t1_c10", 8'd10, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(C5,  "t1_c5",  8'd15, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        req_base = req_cycles;
        applyStimulus(SA,  "t1_sel", 8'd0, 8'd15, 8'd0, 1'b1, 1'b0, 1'b0, 1'b1);
        runTicks(1999);
        applyStimulus(C5,  "t1_open_coin", 8'd0, 8'd15, 8'd0, 1'b1, 1'b0, 1'b1, 1'b1);
        applyStimulus(TK,  "t1_close", 8'd0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(SA | CN, "t1_idle_ignore", 8'd0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("t1_no_ret_req", 8'(req_cycles - req_base), 8'd0);

        $display("[TB] product B with change, slow ack");
        applyStimulus(C10, "t2_c10a", 8'd10, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(C10, "t2_c10b", 8'd20, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(C10, "t2_c10c", 8'd30, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(SB,  "t2_sel", 8'd0, 8'd25, 8'd5, 1'b1, 1'b0, 1'b0, 1'b1);
        runTicks(1999);
        applyStimulus(TK,  "t2_close", 8'd0, 8'd0, 8'd5, 1'b0, 1'b1, 1'b0, 1'b1);
        applyStimulus(C10, "t2_wait_coin", 8'd0, 8'd0, 8'd5, 1'b0, 1'b1, 1'b1, 1'b1);
        applyStimulus(NONE, "t2_wait2", 8'd0, 8'd0, 8'd5, 1'b0, 1'b1, 1'b0, 1'b1);
        applyStimulus(NONE, "t2_wait3", 8'd0, 8'd0, 8'd5, 1'b0, 1'b1, 1'b0, 1'b1);
        applyStimulus(ACK, "t2_ack", 8'd0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0);

        $display("[TB] insufficient credit, then top up");
        applyStimulus(C10, "t3_c10a", 8'd10, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(SB,  "t3_short", 8'd10, 8'd25, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(C10, "t3_c10b", 8'd20, 8'd25, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(C10, "t3_c10c", 8'd30, 8'd25, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(SB,  "t3_sel", 8'd0, 8'd25, 8'd5, 1'b1, 1'b0, 1'b0, 1'b1);
        runTicks(1999);
        applyStimulus(TK,  "t3_close", 8'd0, 8'd0, 8'd5, 1'b0, 1'b1, 1'b0, 1'b1);
        applyStimulus(ACK, "t3_ack", 8'd0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0);

        $display("[TB] credit ceiling and cancel refund");
        applyStimulus(C10, "t4_c10a", 8'd10, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(C10, "t4_c10b", 8'd20, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(C10, "t4_c10c", 8'd30, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(C10, "t4_c10d", 8'd40, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(C5,  "t4_c5", 8'd45, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(C10, "t4_reject", 8'd45, 8'd0, 8'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        applyStimulus(NONE, "t4_after_reject", 8'd45, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(CN,  "t4_cancel", 8'd0, 8'd0, 8'd45, 1'b0, 1'b1, 1'b0, 1'b1);
        drainPayout(45);
        applyStimulus(C5 | C10, "t4_both", 8'd15, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0);

        $display("[TB] cancel with same-cycle coin");
        applyStimulus(C5, "t5_c5", 8'd20, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(CN | C10, "t5_cancel", 8'd0, 8'd0, 8'd20, 1'b0, 1'b1, 1'b1, 1'b1);
        drainPayout(20);

        $display("[TB] select priority and coin over select");
        applyStimulus(C10, "t6_c10", 8'd10, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(SA | SB, "t6_a_wins", 8'd10, 8'd15, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(C5 | SA, "t6_coin_first", 8'd15, 8'd15, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(CN, "t6_cancel", 8'd0, 8'd0, 8'd15, 1'b0, 1'b1, 1'b0, 1'b1);
        drainPayout(15);

        $display("[TB] idle timeout refund and reset mid-payout");
        applyStimulus(C10, "t7_c10", 8'd10, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        runTicks(9999);
        applyStimulus(NONE, "t7_pre_timeout", 8'd10, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(TK, "t7_timeout", 8'd0, 8'd0, 8'd10, 1'b0, 1'b1, 1'b0, 1'b1);
        applyStimulus(ACK, "t7_ack", 8'd0, 8'd0, 8'd5, 1'b0, 1'b0, 1'b0, 1'b1);
        applyStimulus(NONE, "t7_gap", 8'd0, 8'd0, 8'd5, 1'b0, 1'b1, 1'b0, 1'b1);
        applyStimulus(RST, "t7_reset", 8'd0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(SA, "t7_after_reset", 8'd0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule

// File: doc/vend_ctrl.md
Name: vend_ctrl

Overview:
- Transaction sequencer for the coin-operated vending datapath.
- Accepts debounced single-cycle coin pulses and product-select / cancel pulses, and accumulates credit.
- Decides vend or refund, holds the dispense gate open for a timed window, then pays change out one 5-unit coin at a time over a req/ack handshake to the coin-return actuator.
- Its price/credit/change outputs feed the existing bin-to-BCD and 7-segment scan path; its timer uses the shared 1 ms enable tick.

Parameters:
- PRICE_A, 15, price of product A (multiple of 5, 5..255).
- PRICE_B, 25, price of product B (multiple of 5, 5..255).
- MAX_CREDIT, 50, credit ceiling; coins that would exceed it are rejected.
- OPEN_MS, 2000, dispense-gate open time in tick_1ms periods.
- TIMEOUT_MS, 10000, idle time in CREDIT before auto-refund, in tick_1ms periods.

Ports:
- sys_clk  in  1  system clock; the only clock.
- sys_rst  in  1  synchronous, active-high reset.
- tick_1ms  in  1  one-cycle enable, every 1 ms.
- coin5  in  1  one-cycle pulse: 5-unit coin inserted.
- coin10  in  1  one-cycle pulse: 10-unit coin inserted.
- sel_a  in  1  one-cycle pulse: select product A.
- sel_b  in  1  one-cycle pulse: select product B.
- cancel  in  1  one-cycle pulse: abort and refund.
- ret_ack  in  1  actuator accepted one 5-unit coin.
- credit  out  8  current accumulated credit.
- price  out  8  latched price of the last selection, else 0.
- change  out  8  change/refund remaining to pay out.
- open  out  1  dispense gate.
- ret_req  out  1  request to eject one 5-unit coin.
- coin_reject  out  1  one-cycle pulse: coin refused.
- busy  out  1  high in DISPENSE or PAYOUT.

Behaviour:
- Reset (synchronous, sys_rst high at a clock edge): state IDLE; credit, price, change = 0; open, ret_req, coin_reject, busy = 0; timers cleared. Reset mid-transaction abandons credit and change (no payout).
- All outputs are registered and update on the edge after the qualifying input. Coin value per cycle is 5·coin5 + 10·coin10; both pulses in one cycle add 15.
- IDLE:
  - An accepted coin loads credit and moves to CREDIT.
  - sel_a/sel_b/cancel are ignored.
- CREDIT:
  - Priority in one cycle: cancel > coin > select.
  - cancel: change <= credit, credit <= 0, price <= 0, go to PAYOUT. A same-cycle coin is rejected.
  - coin: if credit+value <= MAX_CREDIT, credit += value; else credit is unchanged and coin_reject pulses. A select in the same cycle is ignored.
  - select (sel_a wins over sel_b): price <= selected price. If credit >= price: change <= credit - price, credit <= 0, go to DISPENSE. Else stay in CREDIT, price remains displayed.
  - Timeout counter: clears on any accepted coin or select; increments on tick_1ms. On reaching TIMEOUT_MS it acts as cancel.
- DISPENSE:
  - open = 1, busy = 1.
  - Counts OPEN_MS ticks. At the end, open <= 0 and price <= 0; go to PAYOUT if change != 0, else IDLE.
  - cancel is ignored.
- PAYOUT:
  - ret_req = 1 while change != 0.
  - On a cycle with ret_req & ret_ack: change -= 5 and ret_req <= 0 for exactly one cycle, then re-asserts if change is still nonzero.
  - When change reaches 0, go to IDLE.
  - ret_ack while ret_req = 0 is ignored. cancel is ignored.
  - ret_req holds indefinitely without ack; there is no timeout here.
- Any coin in DISPENSE or PAYOUT pulses coin_reject and does not alter credit.
- Arithmetic: 8-bit unsigned. Parameter constraints guarantee no overflow. change is always a multiple of 5.

Test Plan:
- coin10, coin5, sel_a (defaults) -> credit 10 then 15; DISPENSE with change 0, open high for 2000 ticks, then IDLE with all outputs 0, ret_req never asserted.
- coin10 ×3, sel_b -> credit 30; change 5, DISPENSE, then PAYOUT. ret_req high; ack after 3 cycles -> change 0, ret_req low, IDLE.
- coin10, sel_b -> price 25, credit 10, stays in CREDIT. Then coin10 ×2, sel_b -> change 5, DISPENSE.
- Credit 45, then coin10 -> coin_reject pulses once, credit stays 45. coin5 and coin10 in the same cycle from credit 0 -> credit 15.
- Credit 20, then cancel and coin10 in the same cycle -> coin_reject, change 20. Four req/ack cycles with ret_req low one cycle between each; change steps 15, 10, 5, 0; then IDLE.
- TIMEOUT_MS=20, OPEN_MS=4: coin10, no activity for 20 ticks -> PAYOUT with change 10, two acks. sys_rst asserted mid-PAYOUT -> next cycle IDLE with all outputs 0.
